// File: rtl/lcd_fb_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_fb_arbiter
//   Single-port frame-buffer BRAM arbiter. Display scan-out reads win any
//   cycle the timing controller asserts iDE; writer words wait in a small FIFO
//   and are drained into the BRAM one per blanking cycle.
//
// Optional feature macro: LCD_ARB_STALL_CNT_EN
//   When defined, adds oSTALL_CNT, a saturating count of cycles in which the
//   writer was held off (iWR_VALID=1, oWR_READY=0), cleared on each falling
//   edge of iVSYNC.
//
// Ports:
//   iCLK        pixel clock (shared with the LCD timing controller)
//   inRST       asynchronous active-low reset
//   iDE         display data-enable
//   iADDR       display read address, valid while iDE=1
//   iVSYNC      vertical sync, active low
//   iWR_VALID   writer has a word
//   oWR_READY   FIFO accepts a word this cycle
//   iWR_ADDR    writer address
//   iWR_DATA    writer data
//   oBRAM_ADDR  BRAM address (registered)
//   oBRAM_WE    BRAM write enable (registered)
//   oBRAM_WDATA BRAM write data (registered)
//   iBRAM_RDATA BRAM read data, one-cycle read latency
//   oPIX_DATA   pixel to the panel
//   oPIX_VALID  oPIX_DATA carries a scanned-out pixel
//   oFIFO_LEVEL FIFO occupancy
//   oSTALL_CNT  writer stall counter (only with LCD_ARB_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module lcd_fb_arbiter #(
  parameter int ABW        = 19,
  parameter int DBW        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LBW        = 3
) (
  input  logic           iCLK,
  input  logic           inRST,
  input  logic           iDE,
  input  logic [ABW-1:0] iADDR,
  input  logic           iVSYNC,
  input  logic           iWR_VALID,
  output logic           oWR_READY,
  input  logic [ABW-1:0] iWR_ADDR,
  input  logic [DBW-1:0] iWR_DATA,
  output logic [ABW-1:0] oBRAM_ADDR,
  output logic           oBRAM_WE,
  output logic [DBW-1:0] oBRAM_WDATA,
  input  logic [DBW-1:0] iBRAM_RDATA,
  output logic [DBW-1:0] oPIX_DATA,
  output logic           oPIX_VALID,
`ifdef LCD_ARB_STALL_CNT_EN
  output logic [15:0]    oSTALL_CNT,
`endif
  output logic [LBW-1:0] oFIFO_LEVEL
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           w_pop;
  logic           w_push;
  logic           w_full;
  logic           w_empty;

  logic [ABW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DBW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [LBW-1:0] r_level;
  logic           r_rst_done;

  logic [ABW-1:0] r_bram_addr;
  logic [DBW-1:0] r_bram_wdata;
  logic           r_rd_pend;
  logic           r_rd_pend_d;
  logic           r_pix_valid;
  logic [DBW-1:0] r_pix_data;

  assign w_full    = (r_level == LBW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // Ready is held low until one clock after reset release so the writer
  // cannot push while the pointers are still coming out of reset.
  assign oWR_READY = r_rst_done & ~w_full;
  assign w_push    = iWR_VALID & oWR_READY;

  // Next-state decision: scan-out always wins; the FIFO drains only when
  // iDE is low, so a write can never land in an active-video cycle.
  always_comb begin
    w_state_next = S_IDLE;
    w_pop        = 1'b0;
    if (iDE) begin
      w_state_next = S_READ;
    end else if (!w_empty) begin
      w_state_next = S_WRITE;
      w_pop        = 1'b1;
    end
  end

  // FIFO storage: no reset, contents are only meaningful between pointers.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= iWR_ADDR;
      r_fifo_data[r_wr_ptr] <= iWR_DATA;
    end
  end

  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_rst_done <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LBW'(1);
        2'b01:   r_level <= r_level - LBW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_state      <= S_IDLE;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (w_state_next)
        S_READ:  r_bram_addr <= iADDR;
        S_WRITE: begin
          r_bram_addr  <= r_fifo_addr[r_rd_ptr];
          r_bram_wdata <= r_fifo_data[r_rd_ptr];
        end
        default: r_bram_addr <= r_bram_addr;
      endcase
    end
  end

  // The address is registered here, and the BRAM registers its output one
  // edge later, so read data for an iDE cycle is on iBRAM_RDATA during the
  // second cycle after it. r_rd_pend_d marks exactly that cycle.
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_rd_pend   <= 1'b0;
      r_rd_pend_d <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_rd_pend   <= iDE;
      r_rd_pend_d <= r_rd_pend;
      r_pix_valid <= r_rd_pend_d;
      if (r_rd_pend_d) r_pix_data <= iBRAM_RDATA;
    end
  end

  assign oBRAM_ADDR  = r_bram_addr;
  assign oBRAM_WDATA = r_bram_wdata;
  assign oBRAM_WE    = (r_state == S_WRITE);
  assign oPIX_DATA   = r_pix_data;
  assign oPIX_VALID  = r_pix_valid;
  assign oFIFO_LEVEL = r_level;

`ifdef LCD_ARB_STALL_CNT_EN
  logic        r_vsync_d;
  logic [15:0] r_stall_cnt;

  // Reset r_vsync_d high so a low iVSYNC right after reset counts as a fall.
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_vsync_d   <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_vsync_d <= iVSYNC;
      if (r_vsync_d && !iVSYNC) begin
        r_stall_cnt <= '0;
      end else if (iWR_VALID && !oWR_READY && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign oSTALL_CNT = r_stall_cnt;
`else
  // iVSYNC only feeds the stall counter.
  logic w_unused_vsync;
  assign w_unused_vsync = iVSYNC;
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
module tb_lcd_fb_arbiter;

  localparam int ABW   = 19;
  localparam int DBW   = 16;
  localparam int DEPTH = 4;
  localparam int LBW   = 3;

  logic           iCLK = 1'b0;
  logic           inRST;
  logic           iDE;
  logic [ABW-1:0] iADDR;
  logic           iVSYNC;
  logic           iWR_VALID;
  logic           oWR_READY;
  logic [ABW-1:0] iWR_ADDR;
  logic [DBW-1:0] iWR_DATA;
  logic [ABW-1:0] oBRAM_ADDR;
  logic           oBRAM_WE;
  logic [DBW-1:0] oBRAM_WDATA;
  logic [DBW-1:0] iBRAM_RDATA;
  logic [DBW-1:0] oPIX_DATA;
  logic           oPIX_VALID;
  logic [LBW-1:0] oFIFO_LEVEL;
  logic [15:0]    oSTALL_CNT;

  always #5 iCLK = ~iCLK;

  lcd_fb_arbiter #(.ABW(ABW), .DBW(DBW), .FIFO_DEPTH(DEPTH), .LBW(LBW)) dut (
    .iCLK(iCLK), .inRST(inRST), .iDE(iDE), .iADDR(iADDR), .iVSYNC(iVSYNC),
    .iWR_VALID(iWR_VALID), .oWR_READY(oWR_READY), .iWR_ADDR(iWR_ADDR),
    .iWR_DATA(iWR_DATA), .oBRAM_ADDR(oBRAM_ADDR), .oBRAM_WE(oBRAM_WE),
    .oBRAM_WDATA(oBRAM_WDATA), .iBRAM_RDATA(iBRAM_RDATA), .oPIX_DATA(oPIX_DATA),
    .oPIX_VALID(oPIX_VALID),
`ifdef LCD_ARB_STALL_CNT_EN
    .oSTALL_CNT(oSTALL_CNT),
`endif
    .oFIFO_LEVEL(oFIFO_LEVEL)
  );

`ifndef LCD_ARB_STALL_CNT_EN
  assign oSTALL_CNT = 16'h0;
`endif

  // Initial frame-buffer contents (never written in the scan-out region 64..255).
  function automatic logic [15:0] pre(input logic [11:0] a);
    logic [15:0] v;
    if (a == 12'd100) v = 16'h1234;
    else v = ({4'h0, a} * 16'h9E37) ^ 16'h5A5A;
    return v;
  endfunction

  // BRAM model: synchronous write, one-cycle registered read.
  logic [15:0] mem     [0:4095];
  logic        written [0:4095];
  always @(posedge iCLK) begin
    if (oBRAM_WE) begin
      mem[oBRAM_ADDR[11:0]]     <= oBRAM_WDATA;
      written[oBRAM_ADDR[11:0]] <= 1'b1;
    end
    iBRAM_RDATA <= (written[oBRAM_ADDR[11:0]] === 1'b1) ? mem[oBRAM_ADDR[11:0]]
                                                         : pre(oBRAM_ADDR[11:0]);
  end

  // Reference model: a queue for the FIFO, short history for the pixel path.
  typedef struct packed {
    logic [ABW-1:0] a;
    logic [DBW-1:0] d;
  } ent_t;
  ent_t           q[$];
  logic           m_rst_done;
  logic           m_we;
  logic [ABW-1:0] m_addr;
  logic [DBW-1:0] m_wdata;
  logic           m_pix_valid;
  logic [DBW-1:0] m_pix_data;
  logic           h1, h2;
  logic [ABW-1:0] a1, a2;
  logic [15:0]    m_stall;
  logic           m_vs_prev;

  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    q.delete();
    m_rst_done = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_pix_valid = 1'b0; m_pix_data = '0;
    h1 = 1'b0; h2 = 1'b0; a1 = '0; a2 = '0;
    m_stall = '0; m_vs_prev = 1'b1;
  endtask

  // Apply one clock edge's worth of rules to the model, using the inputs
  // currently driven.
  task automatic model_edge();
    logic rdy, push;
    ent_t e;
    if (!inRST) begin
      model_reset();
      return;
    end
    rdy  = m_rst_done && (q.size() < DEPTH);
    push = iWR_VALID && rdy;
    if (m_vs_prev && !iVSYNC) m_stall = '0;
    else if (iWR_VALID && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    m_vs_prev = iVSYNC;
    m_pix_valid = h2;
    if (h2) m_pix_data = pre(a2[11:0]);
    h2 = h1; a2 = a1; h1 = iDE; a1 = iADDR;
    if (iDE) begin
      m_we = 1'b0; m_addr = iADDR;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_addr = e.a; m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (push) q.push_back('{a: iWR_ADDR, d: iWR_DATA});
    m_rst_done = 1'b1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    inRST = 1'b0;
    repeat (10) tick();
    checks++; if (oBRAM_WE !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", oBRAM_WE); end
    checks++; if (oBRAM_ADDR !== '0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", oBRAM_ADDR); end
    checks++; if (oBRAM_WDATA !== '0) begin failures++; $display("FAIL rst_wdata got=%0h exp=0", oBRAM_WDATA); end
    checks++; if (oPIX_DATA !== '0) begin failures++; $display("FAIL rst_pix_data got=%0h exp=0", oPIX_DATA); end
    checks++; if (oPIX_VALID !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got=%0b exp=0", oPIX_VALID); end
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL rst_level got=%0d exp=0", oFIFO_LEVEL); end
    checks++; if (oWR_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", oWR_READY); end
    checks++; if (oSTALL_CNT !== 16'h0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", oSTALL_CNT); end
    inRST = 1'b1;
    checks++; if (oWR_READY !== 1'b0) begin failures++; $display("FAIL rel_ready_before_edge got=%0b exp=0", oWR_READY); end
    tick();
    checks++; if (oWR_READY !== 1'b1) begin failures++; $display("FAIL rel_ready got=%0b exp=1", oWR_READY); end
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL rel_level got=%0d exp=0", oFIFO_LEVEL); end
    $display("test_reset done");
  endtask

  task automatic test_read_path();
    iDE = 1'b1; iADDR = 19'd100;
    tick();
    iDE = 1'b0; iADDR = '0;
    checks++; if (oBRAM_ADDR !== 19'd100) begin failures++; $display("FAIL rd_addr got=%0d exp=100", oBRAM_ADDR); end
    checks++; if (oBRAM_WE !== 1'b0) begin failures++; $display("FAIL rd_we got=%0b exp=0", oBRAM_WE); end
    tick();
    checks++; if (oPIX_VALID !== 1'b0) begin failures++; $display("FAIL rd_valid_early got=%0b exp=0", oPIX_VALID); end
    tick();
    checks++; if (oPIX_VALID !== 1'b1) begin failures++; $display("FAIL rd_valid got=%0b exp=1", oPIX_VALID); end
    checks++; if (oPIX_DATA !== 16'h1234) begin failures++; $display("FAIL rd_data got=%0h exp=1234", oPIX_DATA); end
    tick();
    checks++; if (oPIX_VALID !== 1'b0) begin failures++; $display("FAIL rd_valid_after got=%0b exp=0", oPIX_VALID); end
    checks++; if (oPIX_DATA !== 16'h1234) begin failures++; $display("FAIL rd_data_hold got=%0h exp=1234", oPIX_DATA); end
    $display("test_read_path done");
  endtask

  task automatic test_buffered_write();
    iDE = 1'b1; iADDR = '0;
    for (int k = 0; k < 4; k++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 19'(10 + k); iWR_DATA = 16'(1 + k);
      tick();
      checks++; if (oBRAM_WE !== 1'b0) begin failures++; $display("FAIL bw_no_we k=%0d got=%0b exp=0", k, oBRAM_WE); end
    end
    iWR_VALID = 1'b0;
    checks++; if (oFIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL bw_level got=%0d exp=4", oFIFO_LEVEL); end
    checks++; if (oWR_READY !== 1'b0) begin failures++; $display("FAIL bw_ready got=%0b exp=0", oWR_READY); end
    iDE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (oBRAM_WE !== 1'b1 || oBRAM_ADDR !== 19'(10 + k) || oBRAM_WDATA !== 16'(1 + k)) begin
        failures++;
        $display("FAIL bw_drain k=%0d got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                 k, oBRAM_WE, oBRAM_ADDR, oBRAM_WDATA, 10 + k, 1 + k);
      end
    end
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL bw_level_end got=%0d exp=0", oFIFO_LEVEL); end
    tick();
    checks++; if (oBRAM_WE !== 1'b0) begin failures++; $display("FAIL bw_idle_we got=%0b exp=0", oBRAM_WE); end
    $display("test_buffered_write done");
  endtask

  task automatic test_priority_race();
    iDE = 1'b1; iADDR = '0;
    iWR_VALID = 1'b1; iWR_ADDR = 19'd20; iWR_DATA = 16'h00AA; tick();
    iWR_ADDR = 19'd21; iWR_DATA = 16'h00BB; tick();
    iWR_VALID = 1'b0;
    iDE = 1'b0; tick();
    checks++; if (oBRAM_WE !== 1'b1 || oBRAM_ADDR !== 19'd20) begin failures++; $display("FAIL race_w1 got we=%0b a=%0d exp we=1 a=20", oBRAM_WE, oBRAM_ADDR); end
    iDE = 1'b1; iADDR = 19'd50; tick();
    checks++; if (oBRAM_WE !== 1'b0 || oBRAM_ADDR !== 19'd50) begin failures++; $display("FAIL race_rd got we=%0b a=%0d exp we=0 a=50", oBRAM_WE, oBRAM_ADDR); end
    iDE = 1'b0; iADDR = '0; tick();
    checks++; if (oBRAM_WE !== 1'b1 || oBRAM_ADDR !== 19'd21 || oBRAM_WDATA !== 16'h00BB) begin
      failures++; $display("FAIL race_w2 got we=%0b a=%0d d=%0h exp we=1 a=21 d=bb", oBRAM_WE, oBRAM_ADDR, oBRAM_WDATA);
    end
    tick();
    checks++; if (oBRAM_WE !== 1'b0 || oFIFO_LEVEL !== '0) begin failures++; $display("FAIL race_end got we=%0b lvl=%0d exp we=0 lvl=0", oBRAM_WE, oFIFO_LEVEL); end
    $display("test_priority_race done");
  endtask

  task automatic test_simul_push_pop();
    iDE = 1'b1; iADDR = '0;
    for (int k = 0; k < 2; k++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 19'(30 + k); iWR_DATA = 16'(16'h300 + 30 + k); tick();
    end
    iDE = 1'b0;
    for (int k = 0; k < 8; k++) begin
      iWR_ADDR = 19'(32 + k); iWR_DATA = 16'(16'h300 + 32 + k);
      tick();
      checks++; if (oFIFO_LEVEL !== 3'd2) begin failures++; $display("FAIL pp_level k=%0d got=%0d exp=2", k, oFIFO_LEVEL); end
      checks++; if (oBRAM_WE !== 1'b1 || oBRAM_ADDR !== 19'(30 + k) || oBRAM_WDATA !== 16'(16'h300 + 30 + k)) begin
        failures++;
        $display("FAIL pp_order k=%0d got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                 k, oBRAM_WE, oBRAM_ADDR, oBRAM_WDATA, 30 + k, 16'h300 + 30 + k);
      end
    end
    iWR_VALID = 1'b0;
    tick(); tick();
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL pp_level_end got=%0d exp=0", oFIFO_LEVEL); end
    $display("test_simul_push_pop done");
  endtask

  task automatic test_random();
    int ok_cnt;
    ok_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) iDE = ~iDE;
      iADDR     = 19'($urandom_range(64, 255));
      iWR_VALID = ($urandom_range(0, 2) != 0);
      iWR_ADDR  = 19'($urandom_range(2048, 4095));
      iWR_DATA  = 16'($urandom);
      iVSYNC    = ((c % 40) >= 3);
      tick();
      checks++; if (oBRAM_WE !== m_we) begin failures++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, oBRAM_WE, m_we); end
      checks++; if (oBRAM_ADDR !== m_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, oBRAM_ADDR, m_addr); end
      checks++; if (oBRAM_WDATA !== m_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d got=%0h exp=%0h", c, oBRAM_WDATA, m_wdata); end
      checks++; if (oFIFO_LEVEL !== LBW'(q.size())) begin failures++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, oFIFO_LEVEL, q.size()); end
      checks++; if (oWR_READY !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, oWR_READY, q.size() < DEPTH); end
      checks++; if (oPIX_VALID !== m_pix_valid) begin failures++; $display("FAIL rnd_pix_valid c=%0d got=%0b exp=%0b", c, oPIX_VALID, m_pix_valid); end
      checks++; if (oPIX_DATA !== m_pix_data) begin failures++; $display("FAIL rnd_pix_data c=%0d got=%0h exp=%0h", c, oPIX_DATA, m_pix_data); end
`ifdef LCD_ARB_STALL_CNT_EN
      checks++; if (oSTALL_CNT !== m_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, oSTALL_CNT, m_stall); end
`endif
      ok_cnt++;
    end
    iDE = 1'b0; iWR_VALID = 1'b0; iVSYNC = 1'b1;
    repeat (6) tick();
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL rnd_drained got=%0d exp=0", oFIFO_LEVEL); end
    $display("test_random done cycles=%0d", ok_cnt);
  endtask

  task automatic test_reset_mid_drain();
    iDE = 1'b1; iADDR = '0;
    for (int k = 0; k < 3; k++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 19'(40 + k); iWR_DATA = 16'(16'h400 + k); tick();
    end
    iWR_VALID = 1'b0; iDE = 1'b0;
    tick();
    checks++; if (oBRAM_WE !== 1'b1) begin failures++; $display("FAIL rmd_we_before got=%0b exp=1", oBRAM_WE); end
    #2;
    inRST = 1'b0;
    model_reset();
    #1;
    checks++; if (oBRAM_WE !== 1'b0) begin failures++; $display("FAIL rmd_we_async got=%0b exp=0", oBRAM_WE); end
    checks++; if (oFIFO_LEVEL !== '0) begin failures++; $display("FAIL rmd_level_async got=%0d exp=0", oFIFO_LEVEL); end
    @(negedge iCLK);
    repeat (3) tick();
    inRST = 1'b1;
    tick();
    checks++; if (oFIFO_LEVEL !== '0 || oBRAM_WE !== 1'b0) begin failures++; $display("FAIL rmd_after got lvl=%0d we=%0b exp lvl=0 we=0", oFIFO_LEVEL, oBRAM_WE); end
    checks++; if (oWR_READY !== 1'b1) begin failures++; $display("FAIL rmd_ready got=%0b exp=1", oWR_READY); end
    $display("test_reset_mid_drain done");
  endtask

`ifdef LCD_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    iDE = 1'b1; iADDR = '0;
    iVSYNC = 1'b1; tick();
    iVSYNC = 1'b0; tick();
    checks++; if (oSTALL_CNT !== 16'd0) begin failures++; $display("FAIL st_clear0 got=%0d exp=0", oSTALL_CNT); end
    for (int k = 0; k < 9; k++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 19'(44 + k); iWR_DATA = 16'(k); tick();
    end
    checks++; if (oSTALL_CNT !== 16'd5) begin failures++; $display("FAIL st_count got=%0d exp=5", oSTALL_CNT); end
    iWR_VALID = 1'b0;
    iVSYNC = 1'b1; tick();
    iVSYNC = 1'b0; tick();
    checks++; if (oSTALL_CNT !== 16'd0) begin failures++; $display("FAIL st_clear got=%0d exp=0", oSTALL_CNT); end
    iVSYNC = 1'b1; iDE = 1'b0;
    repeat (5) tick();
    $display("test_stall_cnt done");
  endtask
`endif

  initial begin
    inRST = 1'b0; iDE = 1'b0; iADDR = '0; iVSYNC = 1'b1;
    iWR_VALID = 1'b0; iWR_ADDR = '0; iWR_DATA = '0;
    model_reset();
    @(negedge iCLK);
    test_reset();
    test_read_path();
    test_buffered_write();
    test_priority_race();
    test_simul_push_pop();
    test_random();
    test_reset_mid_drain();
`ifdef LCD_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
